nor23_result_checker: RTL and testbench

//   Clocked, pipelined result checker downstream of the nor23 DUV.

---
 rtl/nor23_result_checker.sv | 165 ++++++++++++++++
 tb/tb_nor23_result_checker.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nor23_result_checker.sv
// Clocked, pipelined checker that recomputes ~(a|b), compares it to c, and keeps saturating counters with halt-on-error.
// Optional feature macro NOR23_CHK_FIRST_ERR_EN: capture the operands of the first mismatching beat.
module nor23_result_checker #(
  parameter int unsigned WIDTH   = 23,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MAX_ERR = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic             cmp_valid_o,
  output logic             mismatch_o,
  output logic             err_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] chk_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
`ifdef NOR23_CHK_FIRST_ERR_EN
  ,
  output logic [WIDTH-1:0] first_a_o,
  output logic [WIDTH-1:0] first_b_o,
  output logic [WIDTH-1:0] first_c_o
`endif
);

  // Compare the budget at a width that also holds MAX_ERR, so an oversized budget simply never matches.
  localparam int unsigned     CMP_W       = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [CMP_W-1:0] MAX_ERR_EXT = CMP_W'(MAX_ERR);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic             accept;
  logic             update;
  logic             hit_budget;
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_exp_reg;
  logic [WIDTH-1:0] s1_c_reg;
  logic             s2_valid_reg;
  logic             s2_mismatch_reg;
  logic             cmp_valid_reg;
  logic             mismatch_reg;
  logic             err_reg;
  logic [CNT_W-1:0] chk_cnt_reg, chk_cnt_next;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;

  assign in_ready = (state_reg == RUN) && !clear;
  assign accept   = in_valid && in_ready;
  // clear wins over a beat completing in stage 2
  assign update   = s2_valid_reg && !clear;

  always_comb begin
    chk_cnt_next = chk_cnt_reg;
    err_cnt_next = err_cnt_reg;
    if (update) begin
      if (!(&chk_cnt_reg)) chk_cnt_next = chk_cnt_reg + 1'b1;
      if (s2_mismatch_reg && !(&err_cnt_reg)) err_cnt_next = err_cnt_reg + 1'b1;
    end
  end

  assign hit_budget = (MAX_ERR != 0) && update && s2_mismatch_reg &&
                      (CMP_W'(err_cnt_next) == MAX_ERR_EXT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:  if (hit_budget) state_next = HALT;
      HALT: state_next = HALT;
    endcase
    if (clear) state_next = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= RUN;
      s1_valid_reg    <= 1'b0;
      s1_exp_reg      <= '0;
      s1_c_reg        <= '0;
      s2_valid_reg    <= 1'b0;
      s2_mismatch_reg <= 1'b0;
      cmp_valid_reg   <= 1'b0;
      mismatch_reg    <= 1'b0;
      err_reg         <= 1'b0;
      chk_cnt_reg     <= '0;
      err_cnt_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      s1_valid_reg <= accept;
      if (accept) begin
        s1_exp_reg <= ~(a_i | b_i);
        s1_c_reg   <= c_i;
      end
      s2_valid_reg    <= s1_valid_reg && !clear;
      s2_mismatch_reg <= (s1_exp_reg != s1_c_reg);
      cmp_valid_reg   <= update;
      mismatch_reg    <= update && s2_mismatch_reg;
      if (clear) begin
        chk_cnt_reg <= '0;
        err_cnt_reg <= '0;
        err_reg     <= 1'b0;
      end else begin
        chk_cnt_reg <= chk_cnt_next;
        err_cnt_reg <= err_cnt_next;
        if (update && s2_mismatch_reg) err_reg <= 1'b1;
      end
    end
  end

  assign cmp_valid_o = cmp_valid_reg;
  assign mismatch_o  = mismatch_reg;
  assign err_o       = err_reg;
  assign halted_o    = (state_reg == HALT);
  assign chk_cnt_o   = chk_cnt_reg;
  assign err_cnt_o   = err_cnt_reg;

`ifdef NOR23_CHK_FIRST_ERR_EN
  logic [WIDTH-1:0] s1_a_reg, s1_b_reg;
  logic [WIDTH-1:0] s2_a_reg, s2_b_reg, s2_c_reg;
  logic [WIDTH-1:0] first_a_reg, first_b_reg, first_c_reg;

  // Operands ride alongside the beat so they line up with its stage-2 verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a_reg    <= '0;
      s1_b_reg    <= '0;
      s2_a_reg    <= '0;
      s2_b_reg    <= '0;
      s2_c_reg    <= '0;
      first_a_reg <= '0;
      first_b_reg <= '0;
      first_c_reg <= '0;
    end else begin
      if (accept) begin
        s1_a_reg <= a_i;
        s1_b_reg <= b_i;
      end
      s2_a_reg <= s1_a_reg;
      s2_b_reg <= s1_b_reg;
      s2_c_reg <= s1_c_reg;
      if (clear) begin
        first_a_reg <= '0;
        first_b_reg <= '0;
        first_c_reg <= '0;
      end else if (update && s2_mismatch_reg && !err_reg) begin
        first_a_reg <= s2_a_reg;
        first_b_reg <= s2_b_reg;
        first_c_reg <= s2_c_reg;
      end
    end
  end

  assign first_a_o = first_a_reg;
  assign first_b_o = first_b_reg;
  assign first_c_o = first_c_reg;
`endif

endmodule

// File: tb/tb_nor23_result_checker.sv
// Randomized self-checking bench for nor23_result_checker: a default-parameter instance and a CNT_W=4, MAX_ERR=0 instance share stimulus.
// Optional macro NOR23_CHK_FIRST_ERR_EN enables the first-error capture checks.
module tb_nor23_result_checker;

  localparam int W = 23;
  localparam logic [W-1:0] ALL1 = {W{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0;

  logic rdy, cv, mm, err, hlt;
  logic [15:0] chk, errc;
  logic rdy_s, cv_s, mm_s, err_s, hlt_s;
  logic [3:0] chk_s, errc_s;
`ifdef NOR23_CHK_FIRST_ERR_EN
  logic [W-1:0] fa, fb, fc, fa_s, fb_s, fc_s;
`endif

  always #5 clk = ~clk;

  nor23_result_checker #(.WIDTH(W), .CNT_W(16), .MAX_ERR(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy),
    .a_i(a), .b_i(b), .c_i(c),
    .cmp_valid_o(cv), .mismatch_o(mm), .err_o(err), .halted_o(hlt),
    .chk_cnt_o(chk), .err_cnt_o(errc)
`ifdef NOR23_CHK_FIRST_ERR_EN
    , .first_a_o(fa), .first_b_o(fb), .first_c_o(fc)
`endif
  );

  nor23_result_checker #(.WIDTH(W), .CNT_W(4), .MAX_ERR(0)) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy_s),
    .a_i(a), .b_i(b), .c_i(c),
    .cmp_valid_o(cv_s), .mismatch_o(mm_s), .err_o(err_s), .halted_o(hlt_s),
    .chk_cnt_o(chk_s), .err_cnt_o(errc_s)
`ifdef NOR23_CHK_FIRST_ERR_EN
    , .first_a_o(fa_s), .first_b_o(fb_s), .first_c_o(fc_s)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: each accepted beat is due at the output two edges after acceptance.
  typedef struct {
    bit           mis;
    int           due;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } beat_t;

  beat_t q[$];
  beat_t qs[$];
  int chk_m, err_m, chk_ms, err_ms;
  bit errf_m, errf_ms, halt_m;
  logic [W-1:0] fa_m, fb_m, fc_m, fa_ms, fb_ms, fc_ms;

  task automatic model_zero();
    q.delete(); qs.delete();
    chk_m = 0; err_m = 0; chk_ms = 0; err_ms = 0;
    errf_m = 0; errf_ms = 0; halt_m = 0;
    fa_m = '0; fb_m = '0; fc_m = '0; fa_ms = '0; fb_ms = '0; fc_ms = '0;
  endtask

  // Drive one cycle, advance the model across the edge and score the streaming outputs.
  task automatic tick(input bit v, input bit cl, input logic [W-1:0] ta, input logic [W-1:0] tb_op,
                      input logic [W-1:0] tc);
    bit rdy_m, rdy_ms, mis, ecv, emm, ecv_s, emm_s;
    beat_t bt;
    in_valid = v; clear = cl; a = ta; b = tb_op; c = tc;
    #2;
    rdy_m  = !halt_m && !cl;
    rdy_ms = !cl;
    tests++;
    if (rdy !== rdy_m || rdy_s !== rdy_ms) begin
      fails++;
      $display("FAIL in_ready cyc=%0d got=%b/%b exp=%b/%b", cyc, rdy, rdy_s, rdy_m, rdy_ms);
    end
    mis = (tc != ~(ta | tb_op));
    @(posedge clk);
    cyc++;
    ecv = 0; emm = 0; ecv_s = 0; emm_s = 0;
    if (cl) begin
      model_zero();
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        bt = q.pop_front();
        ecv = 1; emm = bt.mis;
        if (chk_m < 65535) chk_m++;
        if (bt.mis) begin
          if (err_m < 65535) err_m++;
          if (!errf_m) begin fa_m = bt.a; fb_m = bt.b; fc_m = bt.c; end
          errf_m = 1;
          if (err_m == 1) halt_m = 1;
        end
      end
      if (qs.size() > 0 && qs[0].due == cyc) begin
        bt = qs.pop_front();
        ecv_s = 1; emm_s = bt.mis;
        if (chk_ms < 15) chk_ms++;
        if (bt.mis) begin
          if (err_ms < 15) err_ms++;
          if (!errf_ms) begin fa_ms = bt.a; fb_ms = bt.b; fc_ms = bt.c; end
          errf_ms = 1;
        end
      end
      bt.mis = mis; bt.due = cyc + 2; bt.a = ta; bt.b = tb_op; bt.c = tc;
      if (v && rdy_m)  q.push_back(bt);
      if (v && rdy_ms) qs.push_back(bt);
    end
    #1;
    tests++;
    if (cv !== ecv || (ecv && mm !== emm)) begin
      fails++;
      $display("FAIL cmp_main cyc=%0d got cv=%b mm=%b exp cv=%b mm=%b", cyc, cv, mm, ecv, emm);
    end
    tests++;
    if (cv_s !== ecv_s || (ecv_s && mm_s !== emm_s)) begin
      fails++;
      $display("FAIL cmp_sat cyc=%0d got cv=%b mm=%b exp cv=%b mm=%b", cyc, cv_s, mm_s, ecv_s, emm_s);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    in_valid = 0; clear = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_zero();
  endtask

  task automatic test_reset();
    in_valid = 0; clear = 0; a = '0; b = '0; c = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (rdy !== 1'b1 || cv !== 1'b0 || mm !== 1'b0 || err !== 1'b0 || hlt !== 1'b0 ||
        chk !== 16'd0 || errc !== 16'd0 || rdy_s !== 1'b1 || chk_s !== 4'd0 || errc_s !== 4'd0) begin
      fails++;
      $display("FAIL reset got rdy=%b cv=%b mm=%b err=%b hlt=%b chk=%0d errc=%0d rdy_s=%b chk_s=%0d errc_s=%0d exp rdy=1 others 0",
               rdy, cv, mm, err, hlt, chk, errc, rdy_s, chk_s, errc_s);
    end
    rst = 0;
    model_zero();
  endtask

  task automatic test_good_beats();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) tick(1, 0, '0, '0, ALL1);
      else       tick(0, 0, '0, '0, '0);
      if (cv === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 3 || chk !== 16'd3 || err !== 1'b0 || errc !== 16'd0) begin
      fails++;
      $display("FAIL good_beats got pulses=%0d chk=%0d err=%b errc=%0d exp 3 3 0 0", pulses, chk, err, errc);
    end
  endtask

  task automatic test_halt();
    do_reset();
    tick(1, 0, 23'd1, '0, '0);
    idle(2);
    tests++;
    if (mm !== 1'b1 || errc !== 16'd1 || hlt !== 1'b1 || err !== 1'b1) begin
      fails++;
      $display("FAIL halt got mm=%b errc=%0d hlt=%b err=%b exp 1 1 1 1", mm, errc, hlt, err);
    end
    tests++;
    if (rdy !== 1'b0) begin
      fails++;
      $display("FAIL halt_ready got=%b exp=0", rdy);
    end
  endtask

  task automatic test_halt_drain();
    do_reset();
    tick(1, 0, 23'd1, '0, '0);
    tick(1, 0, '0, '0, ALL1);
    tick(1, 0, '0, '0, ALL1);
    tick(1, 0, '0, '0, ALL1);
    idle(4);
    tests++;
    if (chk !== 16'd3 || errc !== 16'd1 || hlt !== 1'b1 || chk !== 16'(chk_m)) begin
      fails++;
      $display("FAIL halt_drain got chk=%0d errc=%0d hlt=%b exp 3 1 1", chk, errc, hlt);
    end
    tick(0, 1, '0, '0, '0);
    tests++;
    if (chk !== 16'd0 || errc !== 16'd0 || err !== 1'b0 || hlt !== 1'b0) begin
      fails++;
      $display("FAIL halt_clear got chk=%0d errc=%0d err=%b hlt=%b exp 0 0 0 0", chk, errc, err, hlt);
    end
    clear = 0;
    #1;
    tests++;
    if (rdy !== 1'b1) begin
      fails++;
      $display("FAIL clear_ready got=%b exp=1", rdy);
    end
  endtask

  task automatic test_clear_stage2();
    do_reset();
    tick(1, 0, 23'd1, '0, '0);
    idle(1);
    tick(0, 1, '0, '0, '0);
    idle(3);
    tests++;
    if (errc !== 16'd0 || err !== 1'b0 || chk !== 16'd0 || hlt !== 1'b0 || errc_s !== 4'd0) begin
      fails++;
      $display("FAIL clear_stage2 got errc=%0d err=%b chk=%0d hlt=%b errc_s=%0d exp all 0", errc, err, chk, hlt, errc_s);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1, 0, 23'd1, '0, '0);
    #2 rst = 1;
    #1;
    tests++;
    if (cv !== 1'b0 || rdy !== 1'b1 || chk !== 16'd0) begin
      fails++;
      $display("FAIL async_rst got cv=%b rdy=%b chk=%0d exp 0 1 0", cv, rdy, chk);
    end
    #1 rst = 0;
    model_zero();
    idle(4);
    tests++;
    if (errc !== 16'd0 || chk !== 16'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL async_rst_drain got errc=%0d chk=%0d err=%b exp 0 0 0", errc, chk, err);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) tick(1, 0, 23'd1, '0, '0);
    idle(3);
    tests++;
    if (errc_s !== 4'hF || chk_s !== 4'hF || hlt_s !== 1'b0 || err_s !== 1'b1) begin
      fails++;
      $display("FAIL saturate got errc=%h chk=%h hlt=%b err=%b exp F F 0 1", errc_s, chk_s, hlt_s, err_s);
    end
  endtask

`ifdef NOR23_CHK_FIRST_ERR_EN
  task automatic test_first_err();
    do_reset();
    tick(1, 0, 23'd5, 23'd2, '0);
    tick(1, 0, 23'd9, 23'd9, '0);
    idle(3);
    tests++;
    if (fa !== 23'd5 || fb !== 23'd2 || fc !== 23'd0 || fa_s !== 23'd5 || fb_s !== 23'd2 || fc_s !== 23'd0) begin
      fails++;
      $display("FAIL first_err got %h,%h,%h / %h,%h,%h exp 5,2,0", fa, fb, fc, fa_s, fb_s, fc_s);
    end
  endtask
`endif

  task automatic test_random_good();
    logic [W-1:0] ra, rb;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      tick($urandom_range(0, 9) < 7, 0, ra, rb, ~(ra | rb));
    end
    idle(3);
    tests++;
    if (err !== 1'b0 || errc !== 16'd0 || chk !== 16'(chk_m) || hlt !== 1'b0) begin
      fails++;
      $display("FAIL random_good got err=%b errc=%0d chk=%0d hlt=%b exp 0 0 %0d 0", err, errc, chk, hlt, chk_m);
    end
  endtask

  task automatic test_random_mixed();
    logic [W-1:0] ra, rb, rc;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = ~(ra | rb);
      if ($urandom_range(0, 9) < 3) rc = rc ^ (W'(1) << $urandom_range(0, W - 1));
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, ra, rb, rc);
    end
    idle(3);
    tests++;
    if (chk !== 16'(chk_m) || errc !== 16'(err_m) || err !== errf_m || hlt !== halt_m) begin
      fails++;
      $display("FAIL random_main got chk=%0d errc=%0d err=%b hlt=%b exp %0d %0d %b %b",
               chk, errc, err, hlt, chk_m, err_m, errf_m, halt_m);
    end
    tests++;
    if (chk_s !== 4'(chk_ms) || errc_s !== 4'(err_ms) || err_s !== errf_ms || hlt_s !== 1'b0) begin
      fails++;
      $display("FAIL random_sat got chk=%0d errc=%0d err=%b hlt=%b exp %0d %0d %b 0",
               chk_s, errc_s, err_s, hlt_s, chk_ms, err_ms, errf_ms);
    end
  endtask

  initial begin
    model_zero();
    test_reset();
    test_good_beats();
    test_halt();
    test_halt_drain();
    test_clear_stage2();
    test_async_reset();
    test_saturate();
`ifdef NOR23_CHK_FIRST_ERR_EN
    test_first_err();
`endif
    test_random_good();
    test_random_mixed();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
